rs_cmd_scheduler: RTL and testbench
===================================

# rs_cmd_scheduler

Command scheduler and arbiter for a bank of N clocked RS flip-flops. Two requesters (A, B) post set/reset commands that name one flip-flop; the block arbitrates round-robin, drives one registered R or S pulse at a time, and never asserts R and S together on any flip-flop. It keeps a shadow copy of every flip-flop's state, skips redundant commands, and clears the whole bank after reset.

## Interface
Parameters:
- N, 4, number of RS flip-flops in the bank (2..16)
- IDX_W, 2, index width; 2**IDX_W >= N

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- req_a / req_b  in  1  command request from requester A / B
- op_a / op_b  in  1  1 = set (S pulse), 0 = reset (R pulse)
- idx_a / idx_b  in  IDX_W  target flip-flop index
- ack_a / ack_b  out  1  one-cycle command-complete strobe
- R  out  N  reset drive to the bank, one bit per flip-flop, registered
- S  out  N  set drive to the bank, one bit per flip-flop, registered
- Q_SH  out  N  shadow state of the bank
- busy  out  1  high in every state except IDLE

## Operation
- States: INIT, IDLE, PULSE, SETTLE.
- INIT: entered on reset. R = all ones for exactly one cycle, S = 0, then go to IDLE. Aligns the bank with Q_SH = 0.
- IDLE: sample req_a/req_b.
  - Only one request: grant it.
  - Both requests: grant the requester not granted last (round-robin). last_grant resets to B, so A wins the first tie.
  - On grant: latch op, idx and the requester ID. Update last_grant.
  - If idx >= N, or Q_SH[idx] already equals op (redundant), go to SETTLE with no pulse.
  - Otherwise go to PULSE.
- PULSE: drive S[idx] = 1 (op = 1) or R[idx] = 1 (op = 0). All other R/S bits stay 0. Go to SETTLE.
- SETTLE: R = S = 0. Update Q_SH[idx] = op when a pulse was issued. Assert ack for the granted requester only. Go to IDLE.
- Handshake:
  - Requester holds req/op/idx stable from assertion until ack.
  - A req still high in the cycle after ack is a new command.
  - The ungranted requester keeps waiting. Its inputs are not latched until it is granted.
- Invariant: (R & S) == 0 every cycle, and at most one bit of R|S is set outside INIT.
- Opposite commands to the same idx from A and B are serialized in grant order. The last one applied determines Q_SH.

## Timing
- Reset values (cycle with RST high, visible after that edge): state = INIT, R = 0, S = 0, Q_SH = 0, ack_a = ack_b = 0, busy = 1, last_grant = B.
- After RST falls:
  - First edge: R = all ones.
  - Next edge: R = 0, IDLE, busy = 0.
- Normal command, granted at edge t (IDLE):
  - t+1: R/S pulse, busy = 1.
  - t+2: SETTLE. Pulse removed, Q_SH updated, ack high.
  - t+3: IDLE, ack low.
  - Throughput: one command per 3 cycles.
- Redundant or out-of-range command, granted at t: SETTLE at t+1 with ack high, IDLE at t+2. Q_SH and R/S are unchanged.
- RST high in any state takes priority on that edge:
  - R/S drop immediately.
  - The pending ack is lost; the requester re-issues.
  - Sequence restarts at INIT.
- No combinational path from inputs to outputs.

## Test plan
- Reset release → one cycle of R = 4'b1111, then R = S = 0, busy = 0, Q_SH = 4'b0000.
- A: op = 1, idx = 2 → S = 4'b0100 for one cycle, then ack_a one cycle two edges after grant, Q_SH = 4'b0100. Repeat the same command → no S pulse, ack_a one edge after grant.
- A and B both request in the same IDLE cycle (A set idx 1, B reset idx 1) → A serviced first, then B. S = 4'b0010, then later R = 4'b0010. Final Q_SH[1] = 0. ack_a precedes ack_b by 3 cycles.
- Continuous requests from both for 12 cycles → grants alternate A, B, A, B. The checker sees (R & S) == 0 and popcount(R|S) <= 1 every cycle after INIT.
- N = 3, idx = 3 → ack with no pulse, Q_SH unchanged.
- RST asserted on the PULSE cycle → R = S = 0 next edge, no ack, INIT sequence repeats, Q_SH = 0.

Source files
------------

// File: rtl/rs_cmd_scheduler.sv
// Round-robin command scheduler for a bank of clocked RS flip-flops.
// Two requesters post set/reset commands; one registered R or S pulse is issued at a time.
//
// state  | meaning
// -------+---------------------------------------------------------------
// INIT   | bank-wide R pulse is driven on leaving this state, shadow cleared
// IDLE   | arbitrate req_a/req_b, latch the granted command
// PULSE  | R or S for the latched index is driven on leaving this state
// SETTLE | shadow updated and ack strobed on leaving this state
module rs_cmd_scheduler #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             req_a,
   input  logic             op_a,
   input  logic [IDX_W-1:0] idx_a,
   input  logic             req_b,
   input  logic             op_b,
   input  logic [IDX_W-1:0] idx_b,
   output logic             ack_a,
   output logic             ack_b,
   output logic [N-1:0]     R,
   output logic [N-1:0]     S,
   output logic [N-1:0]     Q_SH,
   output logic             busy
);

   typedef enum logic [1:0] {INIT, IDLE, PULSE, SETTLE} state_t;

   localparam logic [IDX_W:0] N_LIM = (IDX_W+1)'(N);

   state_t           state;
   logic             last_b;
   logic             cmd_b;
   logic             cmd_op;
   logic             cmd_pulse;
   logic [N-1:0]     cmd_mask;

   logic             grant_b;
   logic             sel_op;
   logic [IDX_W-1:0] sel_idx;
   logic [N-1:0]     sel_mask;
   logic             sel_skip;

   // Out-of-range indices shift the one-hot mask to zero, so they can never pulse.
   always_comb begin
      grant_b  = req_b & (~req_a | ~last_b);
      sel_op   = grant_b ? op_b  : op_a;
      sel_idx  = grant_b ? idx_b : idx_a;
      sel_mask = N'(1) << sel_idx;
      sel_skip = ({1'b0, sel_idx} >= N_LIM) || ((|(Q_SH & sel_mask)) == sel_op);
   end

   // Outputs are registered from the current state, so each one appears on the
   // edge that leaves the state producing it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= INIT;
         R         <= '0;
         S         <= '0;
         Q_SH      <= '0;
         ack_a     <= 1'b0;
         ack_b     <= 1'b0;
         busy      <= 1'b1;
         last_b    <= 1'b1;
         cmd_b     <= 1'b0;
         cmd_op    <= 1'b0;
         cmd_pulse <= 1'b0;
         cmd_mask  <= '0;
      end else begin
         busy  <= (state != IDLE);
         R     <= '0;
         S     <= '0;
         ack_a <= 1'b0;
         ack_b <= 1'b0;
         case (state)
            INIT: begin
               R     <= '1;
               state <= IDLE;
            end
            IDLE: begin
               if (req_a | req_b) begin
                  last_b    <= grant_b;
                  cmd_b     <= grant_b;
                  cmd_op    <= sel_op;
                  cmd_mask  <= sel_mask;
                  cmd_pulse <= ~sel_skip;
                  state     <= sel_skip ? SETTLE : PULSE;
               end
            end
            PULSE: begin
               if (cmd_op) S <= cmd_mask;
               else        R <= cmd_mask;
               state <= SETTLE;
            end
            SETTLE: begin
               ack_a <= ~cmd_b;
               ack_b <= cmd_b;
               if (cmd_pulse)
                  Q_SH <= cmd_op ? (Q_SH | cmd_mask) : (Q_SH & ~cmd_mask);
               state <= IDLE;
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_rs_cmd_scheduler.sv
// Directed bench for rs_cmd_scheduler: N=4 instance for the main flow, N=3 instance for out-of-range indices.
module tb_rs_cmd_scheduler;

   logic       CLK = 1'b0;
   logic       RST;
   logic       req_a, op_a, req_b, op_b;
   logic [1:0] idx_a, idx_b;
   logic       ack_a, ack_b, busy;
   logic [3:0] R, S, Q_SH;

   logic       req_a3, op_a3, req_b3, op_b3;
   logic [1:0] idx_a3, idx_b3;
   logic       ack_a3, ack_b3, busy3;
   logic [2:0] R3, S3, Q_SH3;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit inv_en   = 1'b0;

   always #5 CLK = ~CLK;

   rs_cmd_scheduler #(.N(4), .IDX_W(2)) u_dut (
      .CLK(CLK), .RST(RST),
      .req_a(req_a), .op_a(op_a), .idx_a(idx_a),
      .req_b(req_b), .op_b(op_b), .idx_b(idx_b),
      .ack_a(ack_a), .ack_b(ack_b),
      .R(R), .S(S), .Q_SH(Q_SH), .busy(busy)
   );

   rs_cmd_scheduler #(.N(3), .IDX_W(2)) u_dut3 (
      .CLK(CLK), .RST(RST),
      .req_a(req_a3), .op_a(op_a3), .idx_a(idx_a3),
      .req_b(req_b3), .op_b(op_b3), .idx_b(idx_b3),
      .ack_a(ack_a3), .ack_b(ack_b3),
      .R(R3), .S(S3), .Q_SH(Q_SH3), .busy(busy3)
   );

   typedef struct {
      logic       use_b;
      logic       op;
      logic [1:0] idx;
      logic       pulse;
      logic [3:0] exp_r;
      logic [3:0] exp_s;
      logic [3:0] exp_q;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Advance one clock, sample 1 ns after the edge, and check the R/S invariant.
   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
      if (inv_en) begin
         chk("rs_overlap", 32'(R & S), 0);
         chk("rs_onehot", 32'($countones(R | S) > 1), 0);
      end
   endtask

   initial begin
      int s_cyc, a_cyc, r_cyc, b_cyc;
      logic [3:0] s_val, r_val;

      vecs[0] = '{use_b: 1'b0, op: 1'b1, idx: 2'd2, pulse: 1'b1, exp_r: 4'b0000, exp_s: 4'b0100, exp_q: 4'b0100};
      vecs[1] = '{use_b: 1'b0, op: 1'b1, idx: 2'd2, pulse: 1'b0, exp_r: 4'b0000, exp_s: 4'b0000, exp_q: 4'b0100};
      vecs[2] = '{use_b: 1'b1, op: 1'b1, idx: 2'd0, pulse: 1'b1, exp_r: 4'b0000, exp_s: 4'b0001, exp_q: 4'b0101};
      vecs[3] = '{use_b: 1'b1, op: 1'b0, idx: 2'd2, pulse: 1'b1, exp_r: 4'b0100, exp_s: 4'b0000, exp_q: 4'b0001};
      vecs[4] = '{use_b: 1'b0, op: 1'b0, idx: 2'd1, pulse: 1'b0, exp_r: 4'b0000, exp_s: 4'b0000, exp_q: 4'b0001};
      vecs[5] = '{use_b: 1'b0, op: 1'b1, idx: 2'd3, pulse: 1'b1, exp_r: 4'b0000, exp_s: 4'b1000, exp_q: 4'b1001};
      vecs[6] = '{use_b: 1'b1, op: 1'b0, idx: 2'd0, pulse: 1'b1, exp_r: 4'b0001, exp_s: 4'b0000, exp_q: 4'b1000};

      RST = 1'b1;
      req_a = 0; op_a = 0; idx_a = 0; req_b = 0; op_b = 0; idx_b = 0;
      req_a3 = 0; op_a3 = 0; idx_a3 = 0; req_b3 = 0; op_b3 = 0; idx_b3 = 0;

      // Reset and INIT sequence
      tick();
      tick();
      chk("rst_r", 32'(R), 0);
      chk("rst_s", 32'(S), 0);
      chk("rst_q", 32'(Q_SH), 0);
      chk("rst_ack", 32'({ack_a, ack_b}), 0);
      chk("rst_busy", 32'(busy), 1);
      RST = 1'b0;
      tick();
      chk("init_r", 32'(R), 32'hF);
      chk("init_s", 32'(S), 0);
      chk("init_busy", 32'(busy), 1);
      chk("init_r3", 32'(R3), 32'h7);
      tick();
      chk("idle_r", 32'(R), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_q", 32'(Q_SH), 0);
      inv_en = 1'b1;

      // Single-requester commands from the table
      for (int i = 0; i < 7; i++) begin
         if (vecs[i].use_b) begin
            req_b = 1'b1; op_b = vecs[i].op; idx_b = vecs[i].idx;
         end else begin
            req_a = 1'b1; op_a = vecs[i].op; idx_a = vecs[i].idx;
         end
         tick();
         chk($sformatf("v%0d_grant_rs", i), 32'(R | S), 0);
         chk($sformatf("v%0d_grant_ack", i), 32'({ack_a, ack_b}), 0);
         if (vecs[i].pulse) begin
            tick();
            chk($sformatf("v%0d_pulse_s", i), 32'(S), 32'(vecs[i].exp_s));
            chk($sformatf("v%0d_pulse_r", i), 32'(R), 32'(vecs[i].exp_r));
            chk($sformatf("v%0d_pulse_ack", i), 32'({ack_a, ack_b}), 0);
            chk($sformatf("v%0d_pulse_busy", i), 32'(busy), 1);
         end
         tick();
         chk($sformatf("v%0d_ack_a", i), 32'(ack_a), 32'(!vecs[i].use_b));
         chk($sformatf("v%0d_ack_b", i), 32'(ack_b), 32'(vecs[i].use_b));
         chk($sformatf("v%0d_settle_rs", i), 32'(R | S), 0);
         chk($sformatf("v%0d_q", i), 32'(Q_SH), 32'(vecs[i].exp_q));
         req_a = 1'b0;
         req_b = 1'b0;
         tick();
         chk($sformatf("v%0d_ack_clr", i), 32'({ack_a, ack_b}), 0);
         chk($sformatf("v%0d_idle_busy", i), 32'(busy), 0);
      end

      // Simultaneous opposite commands to idx 1: A first, B three cycles later
      s_cyc = -1; a_cyc = -1; r_cyc = -1; b_cyc = -1; s_val = 0; r_val = 0;
      req_a = 1'b1; op_a = 1'b1; idx_a = 2'd1;
      req_b = 1'b1; op_b = 1'b0; idx_b = 2'd1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (S != 0) begin s_cyc = c; s_val = S; end
         if (R != 0) begin r_cyc = c; r_val = R; end
         if (ack_a) begin a_cyc = c; req_a = 1'b0; end
         if (ack_b) begin b_cyc = c; req_b = 1'b0; end
      end
      chk("tie_s_cyc", 32'(s_cyc), 2);
      chk("tie_s_val", 32'(s_val), 32'b0010);
      chk("tie_ack_a_cyc", 32'(a_cyc), 3);
      chk("tie_r_cyc", 32'(r_cyc), 5);
      chk("tie_r_val", 32'(r_val), 32'b0010);
      chk("tie_ack_b_cyc", 32'(b_cyc), 6);
      chk("tie_q", 32'(Q_SH), 32'b1000);

      // Both requesters held high: grants alternate A, B, A, B, A
      req_a = 1'b1; op_a = 1'b1; idx_a = 2'd0;
      req_b = 1'b1; op_b = 1'b0; idx_b = 2'd0;
      for (int c = 1; c <= 15; c++) begin
         tick();
         chk($sformatf("rr_c%0d_ack_a", c), 32'(ack_a), 32'(c % 6 == 3));
         chk($sformatf("rr_c%0d_ack_b", c), 32'(ack_b), 32'(c % 6 == 0));
         chk($sformatf("rr_c%0d_s", c), 32'(S), 32'(c % 6 == 2));
         chk($sformatf("rr_c%0d_r", c), 32'(R), 32'(c % 6 == 5));
      end
      req_a = 1'b0;
      req_b = 1'b0;
      tick();
      chk("rr_q", 32'(Q_SH), 32'b1001);
      chk("rr_busy", 32'(busy), 0);

      // N=3 instance: a valid index pulses, index 3 is acked without a pulse
      req_a3 = 1'b1; op_a3 = 1'b1; idx_a3 = 2'd2;
      tick();
      tick();
      chk("n3_s", 32'(S3), 32'b100);
      tick();
      chk("n3_ack", 32'(ack_a3), 1);
      chk("n3_q", 32'(Q_SH3), 32'b100);
      req_a3 = 1'b0;
      tick();
      req_a3 = 1'b1; op_a3 = 1'b1; idx_a3 = 2'd3;
      tick();
      tick();
      chk("n3_oor_ack", 32'(ack_a3), 1);
      chk("n3_oor_rs", 32'(R3 | S3), 0);
      chk("n3_oor_q", 32'(Q_SH3), 32'b100);
      req_a3 = 1'b0;
      tick();
      chk("n3_oor_busy", 32'(busy3), 0);
      chk("n3_oor_ack_clr", 32'(ack_a3), 0);

      // Reset during the pulse: no ack, INIT repeats, shadow cleared
      req_a = 1'b1; op_a = 1'b0; idx_a = 2'd3;
      tick();
      tick();
      chk("rp_pulse_r", 32'(R), 32'b1000);
      RST = 1'b1;
      tick();
      chk("rp_rs", 32'(R | S), 0);
      chk("rp_ack", 32'({ack_a, ack_b}), 0);
      chk("rp_q", 32'(Q_SH), 0);
      chk("rp_busy", 32'(busy), 1);
      req_a = 1'b0;
      inv_en = 1'b0;
      RST = 1'b0;
      tick();
      chk("rp_init_r", 32'(R), 32'hF);
      chk("rp_init_ack", 32'(ack_a), 0);
      tick();
      chk("rp_idle_r", 32'(R), 0);
      chk("rp_idle_busy", 32'(busy), 0);
      chk("rp_idle_q", 32'(Q_SH), 0);
      chk("rp_idle_ack", 32'(ack_a), 0);
      inv_en = 1'b1;
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
